seq_det_param: RTL and testbench

Parametrised serial bit-pattern detector for single-bit input streams. It is the general successor to the fixed 3-bit "101" Moore detector. It adds:
- configurable pattern width and value, with runtime pattern reload
- overlap and non-overlap matching modes
- a sample-enable qualifier
- a saturating match counter

It sits between a serial input source (switch, UART bit slicer, LFSR) and display/LED logic on the lab board.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_param_if.sv | 35 +++
 rtl/sat_counter.sv | 50 +++++
 rtl/seq_det_param.sv | 75 +++++++
 tb/tb_seq_det_param.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and helpers for the parametrised serial pattern detector.
//   OVL_ON / OVL_OFF : matching mode selectors (overlap / restart after match)
//   PAT_101          : default 3-bit pattern
//   fill_width()     : width of a counter that must hold 0..pat_w
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam logic       OVL_ON  = 1'b1;
    localparam logic       OVL_OFF = 1'b0;
    localparam logic [2:0] PAT_101 = 3'b101;

    // Number of bits needed to count valid history bits from 0 up to pat_w.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// -----------------------------------------------------------------------------
// seq_det_param_if
// Bundles the detector's data/control inputs and its result outputs.
//   en, x       : sample qualifier and serial bit
//   pat_load    : load pat_in into the pattern register
//   pat_in      : new pattern (MSB received first)
//   cnt_clr     : clear match counter and saturation flag
//   z           : one-cycle match pulse
//   match_cnt   : saturating match count
//   cnt_sat     : sticky "counter reached all-ones"
// master = stimulus side, slave = detector side.
// -----------------------------------------------------------------------------
interface seq_det_param_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, x, pat_load, pat_in, cnt_clr,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  en, x, pat_load, pat_in, cnt_clr,
        output z, match_cnt, cnt_sat
    );
endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a sticky saturation flag.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event
//   clr      : zero count and flag (wins over inc)
//   cnt      : current count, holds at all-ones
//   sat      : set once cnt reaches all-ones, cleared only by rst/clr
// -----------------------------------------------------------------------------
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic [W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (inc && (r_cnt != ONES)) begin
            r_cnt <= w_cnt_inc;
            // Flag rises together with the count reaching all-ones.
            if (w_cnt_inc == ONES) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign cnt = r_cnt;
    assign sat = r_sat;

endmodule

// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
// Serial bit-pattern detector with runtime pattern reload, overlap or
// restart-after-match modes, sample enable and a saturating match counter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_det_param_if.slave (en, x, pat_load, pat_in, cnt_clr in;
//              z, match_cnt, cnt_sat out)
// -----------------------------------------------------------------------------
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = PAT_101,
    parameter logic             OVERLAP = OVL_ON,
    parameter int               CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_param_if.slave bus
);

    localparam int               FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic              r_z;

    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], bus.x};
    assign w_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;

    // A match needs a full window of valid bits; this is what keeps an
    // all-zeros pattern from firing straight out of reset.
    assign w_match = bus.en && !bus.pat_load &&
                     (w_fill_nxt == FILL_FULL) && (w_hist_nxt == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_z    <= 1'b0;
        end else if (bus.pat_load) begin
            // The bit sampled alongside a reload is dropped; detection restarts.
            r_pat  <= bus.pat_in;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (bus.en) begin
            r_hist <= w_hist_nxt;
            r_fill <= (w_match && (OVERLAP == OVL_OFF)) ? '0 : w_fill_nxt;
            r_z    <= w_match;
        end else begin
            r_z    <= 1'b0;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_match),
        .clr (bus.cnt_clr),
        .cnt (bus.match_cnt),
        .sat (bus.cnt_sat)
    );

    assign bus.z = r_z;

endmodule

// File: tb/tb_seq_det_param.sv
// -----------------------------------------------------------------------------
// tb_seq_det_param
// Four detector configurations driven by one shared stimulus stream:
//   d0: pattern 101, overlap,    8-bit counter
//   d1: pattern 101, no overlap, 8-bit counter
//   d2: pattern 000, overlap,    8-bit counter
//   d3: pattern 101, overlap,    2-bit counter
// A reference model built from the detector rules predicts every output.
// -----------------------------------------------------------------------------
module tb_seq_det_param;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_det_param_if #(.PAT_W(3), .CNT_W(8)) bus0 ();
    seq_det_param_if #(.PAT_W(3), .CNT_W(8)) bus1 ();
    seq_det_param_if #(.PAT_W(3), .CNT_W(8)) bus2 ();
    seq_det_param_if #(.PAT_W(3), .CNT_W(2)) bus3 ();

    seq_det_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(OVL_ON),  .CNT_W(8))
        d0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_det_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(OVL_OFF), .CNT_W(8))
        d1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_det_param #(.PAT_W(3), .PATTERN(3'b000), .OVERLAP(OVL_ON),  .CNT_W(8))
        d2 (.clk(clk), .rst(rst), .bus(bus2));
    seq_det_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(OVL_ON),  .CNT_W(2))
        d3 (.clk(clk), .rst(rst), .bus(bus3));

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state per configuration: window value, number of
    // valid bits seen since restart, pattern, count, flag, pulse.
    int rpat [4] = '{5, 5, 0, 5};
    int ovl  [4] = '{1, 0, 1, 1};
    int cmax [4] = '{255, 255, 255, 3};
    int mv [4];
    int mf [4];
    int mp [4];
    int mc [4];
    int ms [4];
    int mz [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit xx,
                              input bit ld, input int pin, input bit clr);
        for (int k = 0; k < 4; k++) begin
            bit m;
            m = 1'b0;
            if (r) begin
                mv[k] = 0; mf[k] = 0; mp[k] = rpat[k];
                mz[k] = 0; mc[k] = 0; ms[k] = 0;
            end else begin
                if (ld) begin
                    mp[k] = pin; mf[k] = 0; mz[k] = 0;
                end else if (e) begin
                    // Keep the last three received bits, first-received in the MSB.
                    mv[k] = ((mv[k] * 2) + int'(xx)) % 8;
                    if (mf[k] < 3) mf[k] = mf[k] + 1;
                    m = (mf[k] == 3) && (mv[k] == mp[k]);
                    if (m && ovl[k] == 0) mf[k] = 0;
                    mz[k] = int'(m);
                end else begin
                    mz[k] = 0;
                end
                if (clr) begin
                    mc[k] = 0; ms[k] = 0;
                end else begin
                    if (m && mc[k] < cmax[k]) mc[k] = mc[k] + 1;
                    if (mc[k] == cmax[k]) ms[k] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("d0_z",   32'(bus0.z),         32'(mz[0]));
        chk("d0_cnt", 32'(bus0.match_cnt), 32'(mc[0]));
        chk("d0_sat", 32'(bus0.cnt_sat),   32'(ms[0]));
        chk("d1_z",   32'(bus1.z),         32'(mz[1]));
        chk("d1_cnt", 32'(bus1.match_cnt), 32'(mc[1]));
        chk("d1_sat", 32'(bus1.cnt_sat),   32'(ms[1]));
        chk("d2_z",   32'(bus2.z),         32'(mz[2]));
        chk("d2_cnt", 32'(bus2.match_cnt), 32'(mc[2]));
        chk("d2_sat", 32'(bus2.cnt_sat),   32'(ms[2]));
        chk("d3_z",   32'(bus3.z),         32'(mz[3]));
        chk("d3_cnt", 32'(bus3.match_cnt), 32'(mc[3]));
        chk("d3_sat", 32'(bus3.cnt_sat),   32'(ms[3]));
    endtask

    task automatic drive(input bit r, input bit e, input bit xx,
                         input bit ld, input int pin, input bit clr);
        rst = r;
        bus0.en = e; bus0.x = xx; bus0.pat_load = ld; bus0.pat_in = 3'(pin); bus0.cnt_clr = clr;
        bus1.en = e; bus1.x = xx; bus1.pat_load = ld; bus1.pat_in = 3'(pin); bus1.cnt_clr = clr;
        bus2.en = e; bus2.x = xx; bus2.pat_load = ld; bus2.pat_in = 3'(pin); bus2.cnt_clr = clr;
        bus3.en = e; bus3.x = xx; bus3.pat_load = ld; bus3.pat_in = 3'(pin); bus3.cnt_clr = clr;
    endtask

    task automatic step(input bit r, input bit e, input bit xx,
                        input bit ld, input int pin, input bit clr);
        drive(r, e, xx, ld, pin, clr);
        @(posedge clk);
        cycle++;
        model_step(r, e, xx, ld, pin, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b1, v[i], 1'b0, 0, 1'b0);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset state
        do_reset();
        chk("rst_z",   32'(bus0.z), 32'd0);
        chk("rst_cnt", 32'(bus0.match_cnt), 32'd0);
        chk("rst_sat", 32'(bus0.cnt_sat), 32'd0);

        // Overlapping 10101
        bits(16'b10101, 5);
        chk("t1_z_last",   32'(bus0.z), 32'd1);
        chk("t1_cnt_ovl",  32'(bus0.match_cnt), 32'd2);
        chk("t1_cnt_novl", 32'(bus1.match_cnt), 32'd1);

        // Non-overlap 10101101
        do_reset();
        bits(16'b10101101, 8);
        chk("t2_cnt_novl", 32'(bus1.match_cnt), 32'd2);
        chk("t2_z_novl",   32'(bus1.z), 32'd1);

        // All-zeros pattern, reset mid-stream
        do_reset();
        bits(16'b00, 2);
        chk("t3_no_early", 32'(bus2.z), 32'd0);
        do_reset();
        bits(16'b00, 2);
        chk("t3_fill2", 32'(bus2.z), 32'd0);
        bits(16'b0, 1);
        chk("t3_z",   32'(bus2.z), 32'd1);
        chk("t3_cnt", 32'(bus2.match_cnt), 32'd1);

        // Pattern reload to 110 with a discarded bit
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        bits(16'b110, 3);
        chk("t4_new_pat", 32'(bus0.z), 32'd1);
        bits(16'b101, 3);
        chk("t4_old_pat", 32'(bus0.z), 32'd0);
        chk("t4_cnt", 32'(bus0.match_cnt), 32'd1);

        // Enable gaps are invisible
        do_reset();
        bits(16'b1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("t5_gap_z", 32'(bus0.z), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        bits(16'b01, 2);
        chk("t5_z", 32'(bus0.z), 32'd1);

        // Counter saturation, then clear on a match edge
        do_reset();
        bits(16'b10101010101, 11);
        chk("t6_cnt_sat", 32'(bus3.match_cnt), 32'd3);
        chk("t6_sat", 32'(bus3.cnt_sat), 32'd1);
        chk("t6_cnt_wide", 32'(bus0.match_cnt), 32'd5);
        bits(16'b0, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        chk("t6_clr_cnt", 32'(bus3.match_cnt), 32'd0);
        chk("t6_clr_sat", 32'(bus3.cnt_sat), 32'd0);
        chk("t6_clr_z",   32'(bus3.z), 32'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
